dmem_boot_loader: RTL and testbench

Boot-time program loader and data-memory port arbiter between the single-cycle RV32 core and the data memory. Holds the core in reset, accepts a byte stream from an external host, assembles little-endian 32-bit words and writes them to consecutive data-memory addresses. Once loading completes it releases the core and hands it the memory port. Replaces the ad-hoc reset-qualified external write mux in the top level.

---
 rtl/dmem_boot_loader.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_boot_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_loader.sv
// Boot loader and data-memory port arbiter. Holds the core in reset while a host streams a
// little-endian image into data memory. Optional trailing checksum word: LOADER_CHECKSUM_EN.
module dmem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] count_q, count_d;
  logic [31:0] asm_q, asm_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        count_ok_s;
  logic        last_word_s;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        chk_q, chk_d;
`endif

  assign count_ok_s  = (word_count != 16'd0) && ({16'd0, word_count} <= MAX_W);
  assign last_word_s = (word_idx_q == (count_q - 16'd1));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      byte_cnt_q <= 2'd0;
      word_idx_q <= 16'd0;
      count_q    <= 16'd0;
      asm_q      <= 32'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    chk_d      = chk_q;
`endif
    case (state_q)
      HOLD, RUN: begin
        if (start) begin
          if (count_ok_s) begin
            state_d    = RECV;
            count_d    = word_count;
            error_d    = 1'b0;
            byte_cnt_d = 2'd0;
            word_idx_d = 16'd0;
            asm_d      = 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = 32'd0;
            chk_d      = 1'b0;
`endif
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (in_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
            // Final word of a checksummed image is compared, never written.
            if (chk_q) begin
              if ({in_data, asm_q[23:0]} == sum_q) begin
                state_d = RUN;
                done_d  = 1'b1;
              end else begin
                state_d = HOLD;
                error_d = 1'b1;
              end
            end else begin
              state_d = WRITE;
            end
`else
            state_d = WRITE;
`endif
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = RECV;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + asm_q;
        if (last_word_s) begin
          state_d = RECV;
          chk_d   = 1'b1;
        end else begin
          state_d = RECV;
        end
`else
        if (last_word_s) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = RECV;
        end
`endif
      end
      default: state_d = HOLD;
    endcase
  end

  // Moore outputs, except the RUN-state passthrough of the core's store port
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cpu_reset = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      HOLD: begin
        cpu_reset = 1'b1;
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
        mem_wdata = asm_q;
      end
      RUN: begin
        cpu_reset = 1'b0;
        mem_we    = cpu_mem_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: cpu_reset = 1'b1;
    endcase
  end

  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Self-checking bench for dmem_boot_loader: directed scenarios plus randomized traffic,
// all checked every cycle against a stream-level model of the load protocol.
module tb_dmem_boot_loader;

  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
  localparam int LOAD_CYC = 14;
`else
  localparam bit CHK = 1'b0;
  localparam int LOAD_CYC = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        cpu_mem_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        in_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = held, 1 = loading, 2 = running; loading is tracked as counts of
  // accepted bytes and written words in the host stream.
  int          m_mode = 0;
  int          m_n = 0;
  int          m_nb = 0;
  int          m_nw = 0;
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_sum = 32'd0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

  // A complete word is buffered but not yet written.
  function automatic bit in_write();
    return (m_mode == 1) && (m_nb == 4 * (m_nw + 1)) && (m_nw < m_n);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_n <= 0; m_nb <= 0; m_nw <= 0;
      m_word <= 32'd0; m_sum <= 32'd0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_mode != 1) begin
        if (start) begin
          if (word_count >= 16'd1 && int'(word_count) <= MAXW) begin
            m_mode <= 1; m_n <= int'(word_count); m_nb <= 0; m_nw <= 0;
            m_sum <= 32'd0; m_err <= 1'b0;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (in_write()) begin
        m_nw  <= m_nw + 1;
        m_sum <= m_sum + m_word;
        if ((m_nw + 1 == m_n) && !CHK) begin
          m_mode <= 2; m_done <= 1'b1;
        end
      end else if (in_valid) begin
        m_word <= put_byte(m_word, m_nb % 4, in_data);
        m_nb   <= m_nb + 1;
        if (CHK && (m_nb + 1 == 4 * m_n + 4)) begin
          if (put_byte(m_word, m_nb % 4, in_data) == m_sum) begin
            m_mode <= 2; m_done <= 1'b1;
          end else begin
            m_mode <= 0; m_err <= 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, between clock edges.
  initial begin : cmp
    bit wr;
    forever begin
      @(negedge clk);
      #1;
      wr = in_write();
      if (reset || m_mode == 0) begin
        check("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_mem_we", 32'(mem_we), 32'd0);
        check("hold_mem_addr", mem_addr, 32'd0);
        check("hold_mem_wdata", mem_wdata, 32'd0);
      end else if (m_mode == 2) begin
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_in_ready", 32'(in_ready), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_mem_we", 32'(mem_we), 32'(cpu_mem_we));
        check("run_mem_addr", mem_addr, cpu_addr);
        check("run_mem_wdata", mem_wdata, cpu_wdata);
      end else begin
        check("load_cpu_reset", 32'(cpu_reset), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("load_in_ready", 32'(in_ready), 32'(!wr));
        check("load_mem_we", 32'(mem_we), 32'(wr));
        if (wr) begin
          check("write_addr", mem_addr, BASE + 32'(4 * m_nw));
          check("write_data", mem_wdata, m_word);
        end
      end
      check("done", 32'(done), 32'(m_done));
      check("error", 32'(error), 32'(m_err));
      if (mem_we && busy) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
      end
    end
  end

  // All tasks below start and end at a falling edge.
  task automatic do_start(input logic [15:0] wc);
    start = 1'b1; word_count = wc; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int tries;
    tries = 0;
    in_valid = 1'b1; in_data = b;
    #2;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #2;
      tries++;
    end
    acc_cyc = cyc;
    if (tries >= 50) check("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output int first_cyc);
    int a;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], a);
      if (k == 0) first_cyc = a;
    end
  endtask

  // Returns 2 time units after the falling edge on which done is seen.
  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin : stim
    int c0, d, x;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_error", 32'(error), 32'd0);
    @(negedge clk);

    // Two-word image, bytes offered back to back.
    wq_addr.delete(); wq_data.delete();
    do_start(16'd2);
    send_word(32'h0000_0013, c0);
    send_word(32'h0010_0093, x);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0010_00A6, x);
`endif
    wait_done(d);
    check("load_latency", 32'(d - c0), 32'(LOAD_CYC));
    check("run_cpu_reset_lit", 32'(cpu_reset), 32'd0);
    check("wr_count", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() >= 2) begin
      check("wr0_addr", wq_addr[0], 32'h0000_0000);
      check("wr0_data", wq_data[0], 32'h0000_0013);
      check("wr1_addr", wq_addr[1], 32'h0000_0004);
      check("wr1_data", wq_data[1], 32'h0010_0093);
    end
    @(negedge clk);
    #2;
    check("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);

    // Core store port: passed through in RUN, blocked while loading.
    cpu_mem_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'hDEAD_BEEF;
    #2;
    check("pass_we", 32'(mem_we), 32'd1);
    check("pass_addr", mem_addr, 32'h0000_0040);
    check("pass_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    do_start(16'd1);
    #2;
    check("recv_block_we", 32'(mem_we), 32'd0);
    check("recv_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    send_word(32'hA5A5_0001, x);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hA5A5_0001, x);
`endif
    wait_done(d);
    @(negedge clk);
    cpu_mem_we = 1'b0;

    // Out-of-range counts flag error without leaving RUN.
    do_start(16'd0);
    #2;
    check("zero_cnt_error", 32'(error), 32'd1);
    check("zero_cnt_cpu_reset", 32'(cpu_reset), 32'd0);
    @(negedge clk);
    do_start(16'(MAXW + 1));
    #2;
    check("big_cnt_error", 32'(error), 32'd1);
    check("big_cnt_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    do_start(16'd1);
    #2;
    check("good_start_clears", 32'(error), 32'd0);
    check("good_start_busy", 32'(busy), 32'd1);
    @(negedge clk);
    send_word(32'h1234_5678, x);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h1234_5678, x);
`endif
    wait_done(d);
    @(negedge clk);

    // Largest legal count is accepted; then abort mid-word with reset.
    wq_addr.delete(); wq_data.delete();
    do_start(16'(MAXW));
    #2;
    check("max_cnt_error", 32'(error), 32'd0);
    check("max_cnt_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    send_word(32'hCAFE_F00D, x);
    send_byte(8'h11, x);
    send_byte(8'h22, x);
    reset = 1'b1;
    #2;
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_wr_count", 32'(wq_addr.size()), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("abort_stays_hold", 32'(in_ready), 32'd0);
    @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
    do_start(16'd1);
    send_word(32'h0000_0005, x);
    send_word(32'h0000_0005, x);
    wait_done(d);
    check("chk_ok_cpu_reset", 32'(cpu_reset), 32'd0);
    check("chk_ok_error", 32'(error), 32'd0);
    @(negedge clk);
    do_start(16'd1);
    send_word(32'h0000_0005, x);
    send_word(32'h0000_0006, x);
    #2;
    check("chk_bad_error", 32'(error), 32'd1);
    check("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("chk_bad_no_done", 32'(done), 32'd0);
    check("chk_bad_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
`endif

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 9))
        0:       word_count = 16'd0;
        1:       word_count = 16'($urandom_range(MAXW + 1, 65535));
        default: word_count = 16'($urandom_range(1, 5));
      endcase
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = 8'($urandom);
      cpu_mem_we = 1'($urandom_range(0, 1));
      cpu_addr   = $urandom;
      cpu_wdata  = $urandom;
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; cpu_mem_we = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
